// File: rtl/proj_neighbor_mem.sv
// Paged projection memory: one page per BX, per-page entry counts, registered
// reads of any page while the next BX is being filled.
module proj_neighbor_mem #(
  parameter int WIDTH     = 54,
  parameter int ADDR_BITS = 6,
  parameter int BX_BITS   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   wr_en,
  input  logic [BX_BITS-1:0]     read_bx,
  input  logic [ADDR_BITS-1:0]   read_addr,
  output logic [WIDTH-1:0]       read_data,
  output logic [ADDR_BITS:0]     nentries,
  output logic [BX_BITS-1:0]     wr_bx,
  output logic                   start_out,
  output logic                   overflow
);

  localparam int NPAGES = 1 << BX_BITS;
  localparam int DEPTH  = 1 << (BX_BITS + ADDR_BITS);

  logic [ADDR_BITS:0]           count [NPAGES];
  logic [WIDTH-1:0]             ram [DEPTH];
  logic [WIDTH-1:0]             ram_q;
  logic [BX_BITS-1:0]           act_bx;
  logic [ADDR_BITS:0]           act_cnt;
  logic                         act_full;
  logic                         accept;
  logic                         ram_we;
  logic [BX_BITS+ADDR_BITS-1:0] waddr;
  logic [BX_BITS+ADDR_BITS-1:0] raddr;

  // A word arriving with start belongs to the page being opened, at address 0.
  always_comb begin
    act_bx   = start ? wr_bx + BX_BITS'(1) : wr_bx;
    act_cnt  = start ? '0 : count[wr_bx];
    act_full = act_cnt[ADDR_BITS];
    accept   = wr_en & ~act_full;
    ram_we   = accept & ~reset;
    waddr    = {act_bx, act_cnt[ADDR_BITS-1:0]};
    raddr    = {read_bx, read_addr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bx     <= '0;
      overflow  <= 1'b0;
      start_out <= 1'b0;
      nentries  <= '0;
      for (int i = 0; i < NPAGES; i++) count[i] <= '0;
    end else begin
      start_out <= start;
      nentries  <= count[read_bx];
      if (start) wr_bx <= act_bx;
      if (start || accept)
        count[act_bx] <= act_cnt + {{ADDR_BITS{1'b0}}, accept};
      if (wr_en && act_full) overflow <= 1'b1;
    end
  end

  // RAM contents survive reset; only the write is suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (ram_we) ram[waddr] <= data_in;
    ram_q <= ram[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) read_data <= '0;
    else       read_data <= ram_q;
  end

endmodule

// File: tb/tb_proj_neighbor_mem.sv
// Bench for proj_neighbor_mem: page-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_proj_neighbor_mem;

  localparam logic [53:0] WA = 54'h0A0A0A0A0A0A0A;
  localparam logic [53:0] WB = 54'h0B0B0B0B0B0B0B;
  localparam logic [53:0] WC = 54'h0C0C0C0C0C0C0C;
  localparam logic [53:0] WD = 54'h0D0D0D0D0D0D0D;
  localparam logic [53:0] WE = 54'h0E0E0E0E0E0E0E;
  localparam logic [53:0] WG = 54'h01234567890ABC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [53:0] data_in = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  read_bx = '0;
  logic [5:0]  read_addr = '0;
  logic [53:0] read_data;
  logic [6:0]  nentries;
  logic [2:0]  wr_bx;
  logic        start_out;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  bit run_chk = 1'b0;

  proj_neighbor_mem dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .wr_en(wr_en),
    .read_bx(read_bx), .read_addr(read_addr), .read_data(read_data),
    .nentries(nentries), .wr_bx(wr_bx), .start_out(start_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Model: flat page memory, per-page counts, active page, sticky overflow.
  logic [53:0] mem [512];
  bit          written [512];
  int          cnt [8];
  int          bx = 0;
  bit          ovf = 1'b0;
  logic [53:0] rd_s1 = '0;
  bit          v_s1 = 1'b0;
  logic [53:0] exp_rd = '0;
  bit          exp_rd_v = 1'b0;
  int          exp_nent = 0;
  bit          exp_so = 1'b0;

  initial begin
    for (int i = 0; i < 512; i++) begin mem[i] = '0; written[i] = 1'b0; end
    for (int i = 0; i < 8; i++) cnt[i] = 0;
  end

  always @(posedge clk) begin
    int ra;
    ra = int'(read_bx) * 64 + int'(read_addr);
    if (reset) begin exp_rd = '0; exp_rd_v = 1'b1; end
    else begin exp_rd = rd_s1; exp_rd_v = v_s1; end
    rd_s1 = mem[ra];
    v_s1  = written[ra];
    exp_nent = reset ? 0 : cnt[read_bx];
    exp_so   = reset ? 1'b0 : start;
    if (reset) begin
      bx = 0;
      ovf = 1'b0;
      for (int i = 0; i < 8; i++) cnt[i] = 0;
    end else begin
      if (start) begin
        bx = (bx + 1) % 8;
        cnt[bx] = 0;
      end
      if (wr_en) begin
        if (cnt[bx] < 64) begin
          mem[bx * 64 + cnt[bx]] = data_in;
          written[bx * 64 + cnt[bx]] = 1'b1;
          cnt[bx]++;
        end else ovf = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("m_wr_bx", 64'(wr_bx), 64'(bx));
      chk("m_overflow", 64'(overflow), 64'(ovf));
      chk("m_start_out", 64'(start_out), 64'(exp_so));
      chk("m_nentries", 64'(nentries), 64'(exp_nent));
      if (exp_rd_v) chk("m_read_data", 64'(read_data), 64'(exp_rd));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [53:0] wfill(input int i);
    return 54'h30000000000000 | 54'(i);
  endfunction

  function automatic logic [53:0] wbx(input int k, input int j);
    return 54'h20000000000000 | 54'(k * 16 + j);
  endfunction

  initial begin
    step(); step();
    run_chk = 1'b1;
    chk("reset_wr_bx", 64'(wr_bx), 64'd0);
    chk("reset_nentries", 64'(nentries), 64'd0);
    chk("reset_read_data", 64'(read_data), 64'd0);
    reset = 1'b0;

    // Basic three-word BX
    start = 1'b1; step(); start = 1'b0;
    chk("t1_wr_bx", 64'(wr_bx), 64'd1);
    wr_en = 1'b1; data_in = WA; step();
    data_in = WB; step();
    data_in = WC; step();
    wr_en = 1'b0; read_bx = 3'd1; step();
    chk("t1_nentries", 64'(nentries), 64'd3);
    read_addr = 6'd0; step();
    read_addr = 6'd1; step(); chk("t1_rd_a", 64'(read_data), 64'(WA));
    read_addr = 6'd2; step(); chk("t1_rd_b", 64'(read_data), 64'(WB));
    step(); chk("t1_rd_c", 64'(read_data), 64'(WC));

    // Fill page 1 past capacity
    reset = 1'b1; step(); reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    read_bx = 3'd1;
    for (int i = 0; i < 66; i++) begin
      wr_en = 1'b1; data_in = wfill(i); read_addr = 6'(i % 64); step();
      if (i == 63) chk("t2_ovf_before", 64'(overflow), 64'd0);
      if (i == 64) chk("t2_ovf_rise", 64'(overflow), 64'd1);
    end
    wr_en = 1'b0; step();
    chk("t2_nentries", 64'(nentries), 64'd64);
    for (int a = 0; a < 64; a++) begin read_addr = 6'(a); step(); end
    read_addr = 6'd0; step(); step(); chk("t2_rd0", 64'(read_data), 64'(wfill(0)));
    read_addr = 6'd63; step(); step(); chk("t2_rd63", 64'(read_data), 64'(wfill(63)));
    chk("t2_ovf_sticky", 64'(overflow), 64'd1);

    // start and write in the same cycle
    start = 1'b1; wr_en = 1'b1; data_in = WD; step();
    start = 1'b0; wr_en = 1'b0;
    chk("t3_wr_bx", 64'(wr_bx), 64'd2);
    read_bx = 3'd2; read_addr = 6'd0; step();
    chk("t3_nentries2", 64'(nentries), 64'd1);
    step(); chk("t3_rd_d", 64'(read_data), 64'(WD));
    read_bx = 3'd1; step();
    chk("t3_nentries1", 64'(nentries), 64'd64);

    // Nine BX with two words each, page rollover
    reset = 1'b1; step(); reset = 1'b0;
    chk("t4_ovf_cleared", 64'(overflow), 64'd0);
    for (int k = 0; k < 9; k++) begin
      start = 1'b1; step(); start = 1'b0;
      chk("t4_wr_bx_seq", 64'(wr_bx), 64'((k + 1) % 8));
      for (int j = 0; j < 2; j++) begin
        wr_en = 1'b1; data_in = wbx(k, j); step();
      end
      wr_en = 1'b0;
    end
    read_bx = 3'd1; step(); chk("t4_nent1", 64'(nentries), 64'd2);
    read_bx = 3'd0; step(); chk("t4_nent0", 64'(nentries), 64'd2);
    read_bx = 3'd1; read_addr = 6'd0; step(); step();
    chk("t4_p1_a0", 64'(read_data), 64'(wbx(8, 0)));
    read_addr = 6'd1; step(); step();
    chk("t4_p1_a1", 64'(read_data), 64'(wbx(8, 1)));

    // Reset mid-BX with a concurrent write
    start = 1'b1; step(); start = 1'b0;
    wr_en = 1'b1; data_in = WG; step();
    reset = 1'b1; data_in = WE; step();
    reset = 1'b0; wr_en = 1'b0;
    chk("t5_wr_bx", 64'(wr_bx), 64'd0);
    chk("t5_ovf", 64'(overflow), 64'd0);
    for (int p = 0; p < 8; p++) begin
      read_bx = 3'(p); step();
      chk("t5_nent_zero", 64'(nentries), 64'd0);
    end
    read_bx = 3'd2; read_addr = 6'd1; step(); step();
    chk("t5_not_written", 64'(read_data), 64'(wbx(1, 1)));
    read_addr = 6'd0; step(); step();
    chk("t5_g_kept", 64'(read_data), 64'(WG));
    start = 1'b1; step(); start = 1'b0;
    chk("t5_next_page", 64'(wr_bx), 64'd1);

    // Read the page being written; start_out delay
    read_bx = 3'd1; read_addr = 6'd0; step();
    chk("t6_nent_init", 64'(nentries), 64'd0);
    chk("t6_so_low", 64'(start_out), 64'd0);
    wr_en = 1'b1; data_in = WA; step();
    chk("t6_nent_lag0", 64'(nentries), 64'd0);
    data_in = WB; step();
    chk("t6_nent_lag1", 64'(nentries), 64'd1);
    wr_en = 1'b0; step();
    chk("t6_nent_lag2", 64'(nentries), 64'd2);
    start = 1'b1; step(); start = 1'b0;
    chk("t6_so_high", 64'(start_out), 64'd1);
    step();
    chk("t6_so_fall", 64'(start_out), 64'd0);
    step(); step();

    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proj_neighbor_mem.md
# proj_neighbor_mem

Paged projection memory that sits directly downstream of the neighbour-sector read-in stage. It consumes one of that stage's 54-bit projection outputs together with its matching write-enable bit. Each accepted word is stored in a per-bunch-crossing (BX) page, and the block keeps an entry count for every page. The match engine in the next stage reads a page's entry count and its contents by BX and address, while the following BX is being filled.

## Interface
Parameters:
- WIDTH, 54, projection word width; matches the read-in stage output width.
- ADDR_BITS, 6, address bits per page; page capacity is 2^ADDR_BITS = 64 entries.
- BX_BITS, 3, page-select bits; 2^BX_BITS = 8 pages (BX rolls over every 8).

Ports:
- clk  in  1  main clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  one-cycle pulse marking the first cycle of a new BX.
- data_in  in  WIDTH  projection word from the read-in stage.
- wr_en  in  1  write-enable bit from the read-in stage that accompanies data_in.
- read_bx  in  BX_BITS  page to read.
- read_addr  in  ADDR_BITS  entry within read_bx.
- read_data  out  WIDTH  stored word, registered.
- nentries  out  ADDR_BITS+1  entry count of page read_bx, registered.
- wr_bx  out  BX_BITS  page currently being written.
- start_out  out  1  start delayed one cycle, for the next stage.
- overflow  out  1  sticky flag: at least one write was dropped because its page was full.

## Operation
- Storage: a 2^(BX_BITS+ADDR_BITS) x WIDTH simple dual-port RAM.
  - Write address = {wr_bx, count[wr_bx][ADDR_BITS-1:0]}.
  - Read address = {read_bx, read_addr}.
- Counters: 8 page counters, each ADDR_BITS+1 bits wide (range 0..64).
- Page switch: on a cycle with start=1, wr_bx <= wr_bx+1 (modulo 2^BX_BITS, so 7->0) and the counter of the new page is cleared to 0. The counter of the page being left is frozen.
- Write: when wr_en=1, data_in is written at the current count of the active page and that count increments by 1.
- start and wr_en in the same cycle: the word belongs to the new page. It is written at address 0 of page wr_bx+1, and that page's count becomes 1.
- Full page: if wr_en=1 while the active count is 64, the write is dropped, the count stays at 64, and overflow is set to 1. overflow stays 1 until reset.
- Reading the page currently being written is legal. nentries reflects the count as of the end of the previous cycle.
- Reading an address at or beyond nentries returns stale RAM contents. The consumer must bound its reads by nentries; the block does not check this.
- Reset:
  - wr_bx=0, all 8 counters=0, nentries=0, read_data=0, start_out=0, overflow=0.
  - RAM contents are not cleared.
  - Reset has priority over start and wr_en in the same cycle: nothing is written and wr_bx stays 0.
  - Reset in the middle of a BX discards every count; the next start opens page 1.

## Timing
- Write: data is in RAM from edge N+1, where N is the edge on which wr_en was sampled.
- Counter: count updates on edge N.
- nentries: registered, 1-cycle latency from read_bx.
- read_data: 2-cycle latency from {read_bx, read_addr} (RAM read register plus output register). Fully pipelined: one new read per cycle.
- Write-to-read on the same address: the read returns the new data only if it is presented at least 1 cycle after the write edge.
- start_out: start delayed by exactly 1 cycle.
- wr_bx: changes on the edge on which start is sampled.
- No handshake or back-pressure: the upstream stage may assert wr_en every cycle.

## Test plan
- Reset, then start, then 3 words A, B, C with wr_en=1 on consecutive cycles:
  - wr_bx=1 and nentries(read_bx=1)=3.
  - Reading addresses 0, 1, 2 returns A, B, C, each 2 cycles after its address is presented.
- Fill page 1 with 66 writes: nentries=64, overflow rises on the 65th write and stays 1. Addresses 0..63 hold the first 64 words.
- start and wr_en=1 with word D in the same cycle: D is at page 2 address 0, nentries(2)=1, and page 1's count is unchanged.
- 9 start pulses with 2 writes per BX:
  - wr_bx sequence is 1,2,...,7,0,1.
  - After the 9th start, page 1's count is re-cleared and it then holds only the 2 new words; page 0 holds 2.
- reset asserted mid-BX alongside wr_en=1: all nentries read 0, overflow=0, wr_bx=0, and the word is not written.
- Read page wr_bx while writing to it: nentries tracks the writes with 1-cycle lag, and start_out follows start by exactly 1 cycle.
